// File: rtl/fir_coeff_loader.sv
// fir_coeff_loader
//
// Streams signed FIR tap coefficients from a configuration host into a
// shadow bank over a valid/ready port. Once the whole bank has arrived it is
// copied in one cycle into the active bank that drives fir_direct_pipe. The
// block then holds coeffs_stable low while the pipeline flushes samples that
// were computed with a mix of old and new coefficients.
//
// Optional build macro: FIR_COEFF_SYM_EN (linear-phase mode). When it is
// defined, only ceil(NUM_TAPS/2) words are loaded. Word k is written to both
// tap k and tap NUM_TAPS-1-k, and the centre tap of an odd-length filter is
// written once.
//
// Parameters
//   TAP_COEFF_WIDTH  width of one signed coefficient
//   NUM_TAPS         number of FIR taps (>= 2)
//   SETTLE_CYCLES    cycles coeffs_stable stays low after a commit (0 = none)
//
// Ports
//   clk            clock; all logic updates on the rising edge
//   rst            synchronous active-high reset
//   cfg_start      begin a load (honoured only when idle)
//   cfg_abort      discard the load in progress (honoured only while loading)
//   cfg_valid      coefficient word valid
//   cfg_coeff      coefficient word, tap order 0 upward
//   cfg_ready      high while a load is accepting words
//   busy           high whenever a load, commit or settle is in progress
//   coeff_swap     one-cycle pulse in the first cycle the new bank is visible
//   coeffs_stable  FIR output reflects a single coefficient set
//   tap_coeffs     active bank; tap i at [W*(i+1)-1 : W*i]

module fir_coeff_loader #(
  parameter int TAP_COEFF_WIDTH = 5,
  parameter int NUM_TAPS        = 50,
  parameter int SETTLE_CYCLES   = 51
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                cfg_start,
  input  logic                                cfg_abort,
  input  logic                                cfg_valid,
  input  logic [TAP_COEFF_WIDTH-1:0]          cfg_coeff,
  output logic                                cfg_ready,
  output logic                                busy,
  output logic                                coeff_swap,
  output logic                                coeffs_stable,
  output logic [TAP_COEFF_WIDTH*NUM_TAPS-1:0] tap_coeffs
);

  localparam int W     = TAP_COEFF_WIDTH;
  localparam int IDX_W = $clog2(NUM_TAPS + 1);

`ifdef FIR_COEFF_SYM_EN
  localparam int LOAD_COUNT = (NUM_TAPS + 1) / 2;
`else
  localparam int LOAD_COUNT = NUM_TAPS;
`endif

  // The settle counter only needs to hold SETTLE_CYCLES-1.
  localparam int CNT_W      = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int CNT_INIT_I = (SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LOAD_COUNT - 1);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(CNT_INIT_I);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    COMMIT = 2'd2,
    SETTLE = 2'd3
  } state_t;

  state_t           state_reg;
  logic [IDX_W-1:0] index_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             cfg_ready_reg;
  logic             busy_reg;
  logic             coeff_swap_reg;
  logic             coeffs_stable_reg;

  // A word is written only on a real handshake. An abort in the same cycle
  // wins, so the coincident word is dropped.
  logic wr_fire;
  logic commit_fire;

  assign wr_fire     = (state_reg == LOAD) && cfg_valid && !cfg_abort;
  assign commit_fire = (state_reg == COMMIT);

  // ---------------------------------------------------------------------
  // Control FSM. All outputs are registered and updated together with the
  // state, so each output always matches the state it belongs to.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg         <= IDLE;
      index_reg         <= '0;
      cnt_reg           <= '0;
      cfg_ready_reg     <= 1'b0;
      busy_reg          <= 1'b0;
      coeff_swap_reg    <= 1'b0;
      coeffs_stable_reg <= 1'b1;
    end else begin
      coeff_swap_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (cfg_start) begin
            state_reg     <= LOAD;
            index_reg     <= '0;
            cfg_ready_reg <= 1'b1;
            busy_reg      <= 1'b1;
          end
        end

        LOAD: begin
          if (cfg_abort) begin
            // The active bank and coeffs_stable are left untouched.
            state_reg     <= IDLE;
            cfg_ready_reg <= 1'b0;
            busy_reg      <= 1'b0;
          end else if (cfg_valid) begin
            index_reg <= index_reg + IDX_W'(1);
            if (index_reg == LAST_IDX) begin
              state_reg     <= COMMIT;
              cfg_ready_reg <= 1'b0;
            end
          end
        end

        COMMIT: begin
          // The bank copy happens on this edge, so the swap pulse lines up
          // with the first cycle in which tap_coeffs shows the new bank.
          coeff_swap_reg <= 1'b1;
          if (SETTLE_CYCLES == 0) begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
          end else begin
            state_reg         <= SETTLE;
            cnt_reg           <= CNT_INIT;
            coeffs_stable_reg <= 1'b0;
          end
        end

        SETTLE: begin
          if (cnt_reg == '0) begin
            state_reg         <= IDLE;
            busy_reg          <= 1'b0;
            coeffs_stable_reg <= 1'b1;
          end else begin
            cnt_reg <= cnt_reg - CNT_W'(1);
          end
        end

        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Per-tap shadow and active registers. Each tap compares the load index
  // against its own position (and, in linear-phase mode, against its mirror
  // position). A decoded write enable therefore replaces a wide write mux.
  // ---------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < NUM_TAPS; gi++) begin : g_tap
      logic         tap_we;
      logic [W-1:0] shadow_reg;
      logic [W-1:0] active_reg;

`ifdef FIR_COEFF_SYM_EN
      assign tap_we = wr_fire && ((index_reg == IDX_W'(gi)) ||
                                  (index_reg == IDX_W'(NUM_TAPS - 1 - gi)));
`else
      assign tap_we = wr_fire && (index_reg == IDX_W'(gi));
`endif

      always_ff @(posedge clk) begin
        if (rst) begin
          shadow_reg <= '0;
        end else if (tap_we) begin
          shadow_reg <= cfg_coeff;
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          active_reg <= '0;
        end else if (commit_fire) begin
          active_reg <= shadow_reg;
        end
      end

      assign tap_coeffs[W*gi +: W] = active_reg;
    end
  endgenerate

  assign cfg_ready     = cfg_ready_reg;
  assign busy          = busy_reg;
  assign coeff_swap    = coeff_swap_reg;
  assign coeffs_stable = coeffs_stable_reg;

endmodule

// File: tb/tb_fir_coeff_loader.sv
// Bench for fir_coeff_loader. A timestamp-based model predicts every output
// on every cycle. Directed loads also check literal bank contents, pulse
// counts and settle length.
module tb_fir_coeff_loader;

  localparam int W  = 5;
  localparam int N  = 50;
  localparam int S  = 51;
  localparam int TW = W * N;
`ifdef FIR_COEFF_SYM_EN
  localparam int LC = (N + 1) / 2;
`else
  localparam int LC = N;
`endif
  localparam int RST_WORD = (LC > 32) ? 30 : LC / 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cfg_start = 1'b0;
  logic          cfg_abort = 1'b0;
  logic          cfg_valid = 1'b0;
  logic [W-1:0]  cfg_coeff = '0;
  logic          cfg_ready;
  logic          busy;
  logic          coeff_swap;
  logic          coeffs_stable;
  logic [TW-1:0] tap_coeffs;

  fir_coeff_loader #(
    .TAP_COEFF_WIDTH(W),
    .NUM_TAPS(N),
    .SETTLE_CYCLES(S)
  ) dut (
    .clk(clk),
    .rst(rst),
    .cfg_start(cfg_start),
    .cfg_abort(cfg_abort),
    .cfg_valid(cfg_valid),
    .cfg_coeff(cfg_coeff),
    .cfg_ready(cfg_ready),
    .busy(busy),
    .coeff_swap(coeff_swap),
    .coeffs_stable(coeffs_stable),
    .tap_coeffs(tap_coeffs)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [TW-1:0] act, input logic [TW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at t=%0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // Coefficient patterns used by the directed loads.
  function automatic logic [W-1:0] word(input int pat, input int k);
    case (pat)
      0:       return W'(k % 16);
      1:       return W'(3);
      2:       return W'(k - 8);
      default: return W'((k * 7 + 5) % 32);
    endcase
  endfunction

  // The bank a complete load of pattern pat must produce.
  function automatic logic [TW-1:0] lit_bank(input int pat);
    logic [TW-1:0] v;
    v = '0;
    for (int i = 0; i < N; i++) begin
`ifdef FIR_COEFF_SYM_EN
      v[W*i +: W] = word(pat, (i < LC) ? i : N - 1 - i);
`else
      v[W*i +: W] = word(pat, i);
`endif
    end
    return v;
  endfunction

  // ------------------------------------------------------------------
  // Reference model. It tracks whether a load is open and how many words
  // it has taken. It also records the cycle of the final handshake. All
  // later outputs are windows in time measured from that cycle.
  // ------------------------------------------------------------------
  int            cyc = 0;
  int            hs_cyc = -1000;
  int            m_words = 0;
  bit            m_loading = 1'b0;
  logic [W-1:0]  m_shadow [N];
  logic [W-1:0]  m_bank [N];
  bit            exp_ready = 1'b0;
  bit            exp_busy = 1'b0;
  bit            exp_swap = 1'b0;
  bit            exp_stable = 1'b1;
  logic [TW-1:0] exp_taps = '0;

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (rst) begin
      m_loading = 1'b0;
      m_words   = 0;
      hs_cyc    = -1000;
      for (int i = 0; i < N; i++) begin
        m_shadow[i] = '0;
        m_bank[i]   = '0;
      end
    end else begin
      if (cyc == hs_cyc + 1) begin
        for (int i = 0; i < N; i++) m_bank[i] = m_shadow[i];
      end
      // exp_busy still holds last cycle's value here, i.e. "not idle".
      if (!m_loading && !exp_busy && cfg_start) begin
        m_loading = 1'b1;
        m_words   = 0;
      end else if (m_loading) begin
        if (cfg_abort) begin
          m_loading = 1'b0;
        end else if (cfg_valid && m_words < LC) begin
          m_shadow[m_words] = cfg_coeff;
`ifdef FIR_COEFF_SYM_EN
          m_shadow[N - 1 - m_words] = cfg_coeff;
`endif
          m_words++;
          if (m_words == LC) begin
            m_loading = 1'b0;
            hs_cyc    = cyc;
          end
        end
      end
    end
    exp_ready  = m_loading;
    exp_busy   = m_loading || (cyc >= hs_cyc && cyc <= hs_cyc + S);
    exp_swap   = (cyc == hs_cyc + 1);
    exp_stable = !(cyc >= hs_cyc + 1 && cyc <= hs_cyc + S);
    for (int i = 0; i < N; i++) exp_taps[W*i +: W] = m_bank[i];
  end

  // Per-cycle comparison away from the active edge, plus event counters.
  int swap_total = 0;
  int low_total  = 0;
  int hs_total   = 0;

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cfg_ready",     TW'(cfg_ready),     TW'(exp_ready));
      chk("busy",          TW'(busy),          TW'(exp_busy));
      chk("coeff_swap",    TW'(coeff_swap),    TW'(exp_swap));
      chk("coeffs_stable", TW'(coeffs_stable), TW'(exp_stable));
      chk("tap_coeffs",    tap_coeffs,         exp_taps);
      if (coeff_swap === 1'b1) swap_total++;
      if (coeffs_stable === 1'b0) low_total++;
      if (cfg_valid && cfg_ready === 1'b1 && !cfg_abort) hs_total++;
    end
  end

  // ------------------------------------------------------------------
  // Stimulus
  // ------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_load(input int pat, input bit gap, input int abort_at, input int rst_at);
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    for (int k = 0; k < LC; k++) begin
      cfg_valid = 1'b1;
      cfg_coeff = word(pat, k);
      if (k == abort_at) cfg_abort = 1'b1;
      if (k == rst_at) rst = 1'b1;
      tick();
      cfg_valid = 1'b0;
      cfg_abort = 1'b0;
      if (k == abort_at || k == rst_at) return;
      if (gap && k < LC - 1) tick();
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 300) begin
      tick();
      n++;
    end
    chk("idle_timeout", TW'(busy), TW'(0));
  endtask

  int sw0, lo0, hs0;

  initial begin
    repeat (3) tick();
    rst    = 1'b0;
    chk_en = 1'b1;

    // Reset, then idle
    repeat (10) tick();
    chk("reset_taps",   tap_coeffs,         TW'(0));
    chk("reset_stable", TW'(coeffs_stable), TW'(1));
    chk("reset_busy",   TW'(busy),          TW'(0));
    chk("reset_ready",  TW'(cfg_ready),     TW'(0));
    $display("txn reset_idle: taps=%h stable=%b", tap_coeffs, coeffs_stable);

    // Back-to-back load of k mod 16
    sw0 = swap_total; lo0 = low_total; hs0 = hs_total;
    run_load(0, 1'b0, -1, -1);
    chk("b2b_old_bank_1cyc", tap_coeffs, TW'(0));
    tick();
    chk("b2b_bank_2cyc", tap_coeffs, lit_bank(0));
    chk("b2b_swap_pulse", TW'(coeff_swap), TW'(1));
    wait_idle();
    @(negedge clk);
    chk("b2b_swap_count", TW'(swap_total - sw0), TW'(1));
    chk("b2b_stable_low", TW'(low_total - lo0), TW'(S));
    chk("b2b_handshakes", TW'(hs_total - hs0), TW'(LC));
    $display("txn load_b2b: swaps=%0d low=%0d", swap_total - sw0, low_total - lo0);

    // Different bank, then the mod-16 load again with gaps
    run_load(3, 1'b0, -1, -1);
    wait_idle();
    hs0 = hs_total;
    run_load(0, 1'b1, -1, -1);
    tick();
    chk("gap_bank", tap_coeffs, lit_bank(0));
    wait_idle();
    chk("gap_handshakes", TW'(hs_total - hs0), TW'(LC));
    $display("txn load_gapped: words=%0d", hs_total - hs0);

    // Abort coincident with word 20
    sw0 = swap_total; hs0 = hs_total;
    run_load(1, 1'b0, 20, -1);
    chk("abort_busy",  TW'(busy),      TW'(0));
    chk("abort_ready", TW'(cfg_ready), TW'(0));
    repeat (5) tick();
    chk("abort_bank_kept",  tap_coeffs,                lit_bank(0));
    chk("abort_no_swap",    TW'(swap_total - sw0),     TW'(0));
    chk("abort_words_seen", TW'(hs_total - hs0),       TW'(20));
    $display("txn abort: words=%0d swaps=%0d", hs_total - hs0, swap_total - sw0);

    // cfg_start during SETTLE is ignored
    run_load(3, 1'b0, -1, -1);
    repeat (10) tick();
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    chk("settle_start_busy",  TW'(busy),      TW'(1));
    chk("settle_start_ready", TW'(cfg_ready), TW'(0));
    wait_idle();
    tick();
    chk("settle_start_no_load", TW'(cfg_ready), TW'(0));
    chk("settle_bank", tap_coeffs, lit_bank(3));
    $display("txn settle_start: busy=%b ready=%b", busy, cfg_ready);

    // Reset in the middle of a load
    run_load(0, 1'b0, -1, RST_WORD);
    chk("midrst_taps",   tap_coeffs,         TW'(0));
    chk("midrst_stable", TW'(coeffs_stable), TW'(1));
    chk("midrst_busy",   TW'(busy),          TW'(0));
    chk("midrst_ready",  TW'(cfg_ready),     TW'(0));
    chk("midrst_swap",   TW'(coeff_swap),    TW'(0));
    rst = 1'b0;
    repeat (3) tick();
    chk("midrst_idle_taps", tap_coeffs, TW'(0));
    $display("txn mid_reset: taps=%h busy=%b", tap_coeffs, busy);

`ifdef FIR_COEFF_SYM_EN
    // Linear-phase load of k-8, followed by an impulse through the taps
    begin
      int h [N];
      int y [N];
      lo0 = low_total;
      run_load(2, 1'b0, -1, -1);
      tick();
      chk("sym_bank", tap_coeffs, lit_bank(2));
      wait_idle();
      @(negedge clk);
      chk("sym_stable_low", TW'(low_total - lo0), TW'(S));
      for (int i = 0; i < N; i++) h[i] = int'($signed(tap_coeffs[W*i +: W]));
      for (int n = 0; n < N; n++) begin
        y[n] = 0;
        for (int i = 0; i <= n; i++) y[n] += h[i] * (((n - i) == 0) ? 1 : 0);
      end
      for (int n = 0; n < N / 2; n++) begin
        chk("impulse_value", TW'(y[n]), TW'(n - 8));
        chk("impulse_sym",   TW'(y[n]), TW'(y[N - 1 - n]));
      end
      $display("txn sym_load: tap0=%0d tap49=%0d", y[0], y[N-1]);
    end
`endif

    repeat (3) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
